// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: FSM encodings,
// serial line levels and the bit-index width helper.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;

  // Index of the data bit in flight; never narrower than one bit.
  function automatic int idx_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Baud divider for fifo_uart_tx: free-running 0..CLKS_PER_BIT-1 counter with a
// synchronous clear; o_tick marks the last clock of each serial bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DIV_WIDTH    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [DIV_WIDTH-1:0] LAST_COUNT = DIV_WIDTH'(CLKS_PER_BIT - 1);

  logic [DIV_WIDTH-1:0] r_count;

  assign o_tick = (r_count == LAST_COUNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one word from the byte FIFO whenever it is non-empty and sends it as a UART frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done,
  output logic [2:0]            o_dbg_state
);

  localparam int IDX_W = idx_width(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_next;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  w_tick;
  logic                  w_baud_clr;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  // Counter is held at zero until START so the first bit gets its full width.
  assign w_baud_clr = (r_state == ST_IDLE) || (r_state == ST_LOAD);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DIV_WIDTH    (DIV_WIDTH)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_baud_clr),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_idx_next   = r_idx;
    fifo_rd_en   = 1'b0;
    tx_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rst && en && !fifo_empty) begin
          fifo_rd_en   = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_shift_next = fifo_data;
        w_idx_next   = '0;
        w_state_next = ST_START;
      end
      ST_START: begin
        if (w_tick) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end else begin
            w_shift_next = r_shift >> 1;
            w_idx_next   = r_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick) begin
          tx_done      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The line level is registered from the next state so tx never glitches.
  always_comb begin
    w_tx_next = TX_IDLE;
    case (w_state_next)
      ST_START:  w_tx_next = TX_START;
      ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_next = r_parity;
`endif
      default:   w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= TX_IDLE;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_idx   <= w_idx_next;
      r_tx    <= w_tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_parity <= ^fifo_data;
    end
  end
`endif

  assign tx          = r_tx;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (CLKS_PER_BIT=4, DATA_WIDTH=8) with a small FIFO model.
// Build with UART_TX_PARITY_EN defined to add the parity-frame scenario.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          tx_done;
  logic [2:0]    dbg_state;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] fifo_mem[$];
  int cyc = 0;
  int pop_cyc = 0;
  int pop_count = 0;
  int done_count = 0;
  int bad_pop = 0;

  fifo_uart_tx #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB),
    .DIV_WIDTH    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done),
    .o_dbg_state (dbg_state)
  );

  // clock / reset-free FIFO model: data appears the cycle after a pop
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      if (fifo_empty || !en) bad_pop++;
      pop_cyc = cyc;
      pop_count++;
      if (fifo_mem.size() > 0) fifo_data <= fifo_mem.pop_front();
    end
    fifo_empty <= (fifo_mem.size() == 0);
    if (tx_done === 1'b1) done_count++;
    cyc++;
  end

  // Waits for the start bit, then checks every cycle of the frame against b.
  task automatic expect_frame(input logic [DW-1:0] b, input string name,
                              output int wait_cyc, output int start_cyc);
    logic exp_bits[12];
    logic [2:0] exp;
    int nbits;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) exp_bits[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    exp_bits[DW+1] = ^b;
    exp_bits[DW+2] = 1'b1;
    nbits = DW + 3;
`else
    exp_bits[DW+1] = 1'b1;
    nbits = DW + 2;
`endif
    wait_cyc = 0;
    start_cyc = 0;
    while (tx !== 1'b0 && wait_cyc < 300) begin
      @(negedge clk);
      wait_cyc++;
    end
    vectors++;
    if (tx !== 1'b0) begin
      $display("FAIL %s start_bit: tx=%b required 0 within 300 cycles", name, tx);
      miscompares++;
      return;
    end
    start_cyc = cyc;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < CPB; c++) begin
        exp = {exp_bits[k], (k == nbits - 1) && (c == CPB - 1), 1'b1};
        vectors++;
        if ({tx, tx_done, busy} !== exp) begin
          $display("FAIL %s bit%0d cyc%0d: {tx,tx_done,busy}=%b required %b", name, k, c,
                   {tx, tx_done, busy}, exp);
          miscompares++;
        end
        @(negedge clk);
      end
    end
    vectors++;
    if ({tx, busy, tx_done} !== 3'b100) begin
      $display("FAIL %s frame_end: {tx,busy,tx_done}=%b required 100", name, {tx, busy, tx_done});
      miscompares++;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({tx, busy, fifo_rd_en, tx_done, dbg_state} !== 7'b1000_000) begin
      $display("FAIL reset_state: {tx,busy,rd_en,done,state}=%b required 1000000",
               {tx, busy, fifo_rd_en, tx_done, dbg_state});
      miscompares++;
    end
    rst = 1'b1;
    en = 1'b1;
    fifo_mem.push_back(8'h5A);
    for (int i = 0; i < 50 && busy !== 1'b1; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    vectors++;
    if (tx !== 1'b0) begin
      $display("FAIL reset_pre_tx: tx=%b required 0 (start or bit0 of 0x5A)", tx);
      miscompares++;
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({tx, busy, fifo_rd_en, tx_done} !== 4'b1000) begin
      $display("FAIL reset_async: {tx,busy,rd_en,done}=%b required 1000",
               {tx, busy, fifo_rd_en, tx_done});
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int pc0, dc0, w, s;
    pc0 = pop_count;
    dc0 = done_count;
    fifo_mem.push_back(8'hA5);
    expect_frame(8'hA5, "frame_a5", w, s);
    vectors++;
    if (s - pop_cyc !== 2) begin
      $display("FAIL latency: pop-to-start=%0d required 2", s - pop_cyc);
      miscompares++;
    end
    vectors++;
    if ((pop_count - pc0) !== 1 || (done_count - dc0) !== 1) begin
      $display("FAIL single_counts: pops=%0d dones=%0d required 1 1",
               pop_count - pc0, done_count - dc0);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    int pc0, dc0, w, s;
    pc0 = pop_count;
    dc0 = done_count;
    fifo_mem.push_back(8'h01);
    fifo_mem.push_back(8'h02);
    fifo_mem.push_back(8'h03);
    expect_frame(8'h01, "b2b_01", w, s);
    expect_frame(8'h02, "b2b_02", w, s);
    vectors++;
    if (w !== 2) begin
      $display("FAIL gap_02: extra idle cycles=%0d required 2", w);
      miscompares++;
    end
    expect_frame(8'h03, "b2b_03", w, s);
    vectors++;
    if (w !== 2) begin
      $display("FAIL gap_03: extra idle cycles=%0d required 2", w);
      miscompares++;
    end
    repeat (20) @(negedge clk);
    vectors++;
    if ({fifo_empty, fifo_rd_en, busy, tx} !== 4'b1001) begin
      $display("FAIL b2b_idle: {empty,rd_en,busy,tx}=%b required 1001",
               {fifo_empty, fifo_rd_en, busy, tx});
      miscompares++;
    end
    vectors++;
    if ((pop_count - pc0) !== 3 || (done_count - dc0) !== 3) begin
      $display("FAIL b2b_counts: pops=%0d dones=%0d required 3 3",
               pop_count - pc0, done_count - dc0);
      miscompares++;
    end
  endtask

  task automatic test_enable();
    int pc0, w, s;
    en = 1'b0;
    pc0 = pop_count;
    fifo_mem.push_back(8'h55);
    fifo_mem.push_back(8'h66);
    repeat (100) @(negedge clk);
    vectors++;
    if ((pop_count - pc0) !== 0 || fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL en_low: pops=%0d rd_en=%b busy=%b required 0 0 0",
               pop_count - pc0, fifo_rd_en, busy);
      miscompares++;
    end
    en = 1'b1;
    for (int i = 0; i < 50 && pop_count == pc0; i++) @(negedge clk);
    en = 1'b0;
    expect_frame(8'h55, "en_drop_55", w, s);
    repeat (60) @(negedge clk);
    vectors++;
    if ((pop_count - pc0) !== 1 || fifo_mem.size() !== 1 || busy !== 1'b0) begin
      $display("FAIL en_drop: pops=%0d left=%0d busy=%b required 1 1 0",
               pop_count - pc0, fifo_mem.size(), busy);
      miscompares++;
    end
    en = 1'b1;
    expect_frame(8'h66, "en_resume_66", w, s);
  endtask

  task automatic test_reset_mid_frame();
    int pc0, w, s;
    pc0 = pop_count;
    fifo_mem.push_back(8'hF0);
    fifo_mem.push_back(8'h3C);
    for (int i = 0; i < 50 && tx !== 1'b0; i++) @(negedge clk);
    repeat (17) @(negedge clk);
    vectors++;
    if (tx !== 1'b0 || dbg_state !== 3'd3) begin
      $display("FAIL f0_bit3: tx=%b state=%0d required 0 3", tx, dbg_state);
      miscompares++;
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({tx, busy, fifo_rd_en} !== 3'b100) begin
      $display("FAIL mid_reset: {tx,busy,rd_en}=%b required 100", {tx, busy, fifo_rd_en});
      miscompares++;
    end
    repeat (4) @(negedge clk);
    vectors++;
    if ((pop_count - pc0) !== 1 || fifo_rd_en !== 1'b0) begin
      $display("FAIL in_reset: pops=%0d rd_en=%b required 1 0", pop_count - pc0, fifo_rd_en);
      miscompares++;
    end
    rst = 1'b1;
    expect_frame(8'h3C, "after_reset_3c", w, s);
    vectors++;
    if ((pop_count - pc0) !== 2 || fifo_mem.size() !== 0) begin
      $display("FAIL reset_loss: pops=%0d left=%0d required 2 0", pop_count - pc0, fifo_mem.size());
      miscompares++;
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int w, s;
    fifo_mem.push_back(8'h07);
    fifo_mem.push_back(8'h03);
    expect_frame(8'h07, "parity_07", w, s);
    expect_frame(8'h03, "parity_03", w, s);
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_enable();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    vectors++;
    if (bad_pop !== 0) begin
      $display("FAIL illegal_pop: pops while empty or disabled=%0d required 0", bad_pop);
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
